vd_frame_ctrl: RTL

// Frame sequencer for the conv-encoder -> Viterbi-decoder link. Latches one byte,

---
 rtl/vd_frame_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/vd_frame_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : vd_frame_ctrl
// Description : Frame sequencer for a conv-encoder -> Viterbi-decoder loopback.
//               Sends one payload LSB first plus zero tail bits, rebuilds the
//               decoded payload and reports done / error / timeout.
// Revision    : 1.0 - initial release
// =============================================================================
module vd_frame_ctrl #(
    parameter int SIZE_DATA   = 8,
    parameter int TAIL_BITS   = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [SIZE_DATA-1:0] i_data,
    output logic                 o_busy,
    output logic                 o_dec_clr,
    output logic                 o_enc_bit,
    output logic                 o_enc_valid,
    input  logic                 i_enc_ready,
    input  logic                 i_dec_bit,
    input  logic                 i_dec_valid,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_done,
    output logic                 o_err,
    output logic                 o_timeout
);

    localparam int c_frame_bits = SIZE_DATA + TAIL_BITS;
    localparam int c_cnt_w      = $clog2(c_frame_bits + 1);
    localparam int c_to_w       = $clog2(TIMEOUT_CYC + 1);
    localparam int c_idx_w      = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;

    localparam logic [c_cnt_w-1:0] c_frame_cnt   = c_cnt_w'(c_frame_bits);
    localparam logic [c_cnt_w-1:0] c_last_tx_cnt = c_cnt_w'(c_frame_bits - 1);
    localparam logic [c_cnt_w-1:0] c_payload_cnt = c_cnt_w'(SIZE_DATA);
    localparam logic [c_to_w-1:0]  c_to_last     = c_to_w'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_ENC  = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SIZE_DATA-1:0]   r_tx;
    logic [SIZE_DATA-1:0]   r_rx;
    logic [SIZE_DATA-1:0]   r_data;
    logic [c_cnt_w-1:0]     r_tx_cnt;
    logic [c_cnt_w-1:0]     r_rx_cnt;
    logic [c_to_w-1:0]      r_to_cnt;
    logic                   r_err;
    logic                   r_timeout;

    logic                   w_active;
    logic                   w_accept;
    logic                   w_tx_last;
    logic                   w_rx_full;
    logic                   w_collect;
    logic                   w_to_hit;
    logic                   w_set_to;
    logic                   w_tx_payload;
    logic                   w_rx_payload;
    logic [c_idx_w-1:0]     w_tx_idx;
    logic [c_idx_w-1:0]     w_rx_idx;

    assign w_active     = (r_state == S_ENC) || (r_state == S_WAIT);
    assign w_accept     = (r_state == S_ENC) && i_enc_ready;
    assign w_tx_last    = (r_tx_cnt == c_last_tx_cnt);
    assign w_rx_full    = (r_rx_cnt == c_frame_cnt);
    assign w_collect    = w_active && i_dec_valid && !w_rx_full;
    assign w_to_hit     = w_active && (r_to_cnt == c_to_last);
    assign w_tx_payload = (r_tx_cnt < c_payload_cnt);
    assign w_rx_payload = (r_rx_cnt < c_payload_cnt);
    // Low counter bits address the payload; only used while the count is inside it.
    assign w_tx_idx     = r_tx_cnt[c_idx_w-1:0];
    assign w_rx_idx     = r_rx_cnt[c_idx_w-1:0];

    always_comb begin
        w_next   = r_state;
        w_set_to = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_CLR;
                end
            end
            S_CLR: begin
                w_next = S_ENC;
            end
            S_ENC: begin
                // An unfinished transmit at the deadline is a timeout.
                if (w_to_hit) begin
                    w_next   = S_DONE;
                    w_set_to = 1'b1;
                end else if (w_accept && w_tx_last) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_rx_full) begin
                    w_next = S_DONE;
                end else if (w_to_hit) begin
                    w_next   = S_DONE;
                    w_set_to = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_data    <= '0;
            r_tx_cnt  <= '0;
            r_rx_cnt  <= '0;
            r_to_cnt  <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;

            if ((r_state == S_IDLE) && i_start) begin
                r_tx <= i_data;
            end

            if (r_state == S_CLR) begin
                r_tx_cnt  <= '0;
                r_rx_cnt  <= '0;
                r_rx      <= '0;
                r_to_cnt  <= '0;
                r_err     <= 1'b0;
                r_timeout <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
                if (w_active) begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
                // Tail bits advance the count but are never stored.
                if (w_collect) begin
                    if (w_rx_payload) begin
                        r_rx[w_rx_idx] <= i_dec_bit;
                    end
                    r_rx_cnt <= r_rx_cnt + 1'b1;
                end
                if (w_set_to) begin
                    r_timeout <= 1'b1;
                end
            end

            if (r_state == S_DONE) begin
                r_data <= r_rx;
                r_err  <= (r_rx != r_tx) || r_timeout;
            end
        end
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_dec_clr   = (r_state == S_CLR);
    assign o_enc_valid = (r_state == S_ENC);
    assign o_enc_bit   = (r_state == S_ENC) && w_tx_payload && r_tx[w_tx_idx];
    assign o_done      = (r_state == S_DONE);
    assign o_data      = r_data;
    assign o_err       = r_err;
    assign o_timeout   = r_timeout;

endmodule
`default_nettype wire
